// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off requests onto NUM_VOICES oscillator voices.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy; otherwise the request is dropped.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                       Sys_clk,
  input  logic                       Va_rst,
  input  logic                       Req_valid,
  output logic                       Req_ready,
  input  logic                       Req_on,
  input  logic [6:0]                 Req_note,
  input  logic [31:0]                Req_freq,
  output logic [32*NUM_VOICES-1:0]   Voice_freq,
  output logic [NUM_VOICES-1:0]      Voice_ce,
  output logic [NUM_VOICES-1:0]      Voice_rst,
  output logic                       Stole,
  output logic                       Dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    req_on_q;
  logic [6:0]              req_note_q;
  logic [31:0]             req_freq_q;
  logic                    match_found_q, free_found_q;
  logic [IDX_W-1:0]        match_idx_q, free_idx_q;
  logic [NUM_VOICES-1:0]   active_q;
  logic [6:0]              note_q [NUM_VOICES];
  logic [31:0]             freq_q [NUM_VOICES];
  logic [AGE_W-1:0]        age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   vrst_q;
  logic                    event_q;
`ifdef VOICE_STEAL_EN
  logic                    old_found_q;
  logic [IDX_W-1:0]        old_idx_q;
  logic [AGE_W-1:0]        old_age_q;
`endif

  // Commit decision, derived from the candidates gathered during SCAN.
  logic             load_d, off_d, event_d;
  logic [IDX_W-1:0] tgt_d;

  always_comb begin
    load_d  = 1'b0;
    off_d   = 1'b0;
    event_d = 1'b0;
    tgt_d   = '0;
    if (req_on_q) begin
      if (match_found_q) begin
        load_d = 1'b1;
        tgt_d  = match_idx_q;
      end else if (free_found_q) begin
        load_d = 1'b1;
        tgt_d  = free_idx_q;
      end else begin
`ifdef VOICE_STEAL_EN
        load_d  = 1'b1;
        tgt_d   = old_idx_q;
`endif
        event_d = 1'b1;
      end
    end else if (match_found_q) begin
      off_d = 1'b1;
      tgt_d = match_idx_q;
    end
  end

  always_ff @(posedge Sys_clk or posedge Va_rst) begin
    if (Va_rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      idx_q         <= '0;
      req_on_q      <= 1'b0;
      req_note_q    <= '0;
      req_freq_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      active_q      <= '0;
      vrst_q        <= '0;
      event_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        freq_q[i] <= '0;
        age_q[i]  <= '0;
      end
`ifdef VOICE_STEAL_EN
      old_found_q <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
`endif
    end else begin
      vrst_q  <= '0;
      event_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (Req_valid && ready_q) begin
            ready_q       <= 1'b0;
            req_on_q      <= Req_on;
            req_note_q    <= Req_note;
            req_freq_q    <= Req_freq;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            idx_q         <= '0;
`ifdef VOICE_STEAL_EN
            old_found_q   <= 1'b0;
`endif
            state_q       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (active_q[idx_q] && note_q[idx_q] == req_note_q && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= idx_q;
          end
          if (!active_q[idx_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
`ifdef VOICE_STEAL_EN
          // Strictly-greater keeps the lowest index on equal ages.
          if (active_q[idx_q] && (!old_found_q || age_q[idx_q] > old_age_q)) begin
            old_found_q <= 1'b1;
            old_idx_q   <= idx_q;
            old_age_q   <= age_q[idx_q];
          end
`endif
          if (idx_q == LAST_IDX) state_q <= S_COMMIT;
          else                   idx_q   <= idx_q + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (load_d && IDX_W'(i) == tgt_d) begin
              active_q[i] <= 1'b1;
              note_q[i]   <= req_note_q;
              freq_q[i]   <= req_freq_q;
              age_q[i]    <= '0;
              vrst_q[i]   <= 1'b1;
            end else if (off_d && IDX_W'(i) == tgt_d) begin
              active_q[i] <= 1'b0;
              age_q[i]    <= '0;
            end else if (load_d && active_q[i] && age_q[i] != {AGE_W{1'b1}}) begin
              age_q[i] <= age_q[i] + 1'b1;
            end
          end
          event_q <= event_d;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign Voice_freq[32*gi +: 32] = freq_q[gi];
    end
  endgenerate

  assign Voice_ce  = active_q;
  assign Voice_rst = vrst_q;
  assign Req_ready = ready_q;
`ifdef VOICE_STEAL_EN
  assign Stole   = event_q;
  assign Dropped = 1'b0;
`else
  assign Stole   = 1'b0;
  assign Dropped = event_q;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random requests
// compared against a voice-table model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_on = 1'b0;
  logic [6:0]        req_note = '0;
  logic [31:0]       req_freq = '0;
  logic              req_ready;
  logic [32*NV-1:0]  voice_freq;
  logic [NV-1:0]     voice_ce;
  logic [NV-1:0]     voice_rst;
  logic              stole;
  logic              dropped;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .Sys_clk    (clk),
    .Va_rst     (rst),
    .Req_valid  (req_valid),
    .Req_ready  (req_ready),
    .Req_on     (req_on),
    .Req_note   (req_note),
    .Req_freq   (req_freq),
    .Voice_freq (voice_freq),
    .Voice_ce   (voice_ce),
    .Voice_rst  (voice_rst),
    .Stole      (stole),
    .Dropped    (dropped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference voice table
  bit          m_active [NV];
  int          m_note   [NV];
  logic [31:0] m_freq   [NV];
  int          m_age    [NV];
  logic [NV-1:0] e_rst;
  bit          e_stole, e_drop;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 0; m_note[i] = 0; m_freq[i] = '0; m_age[i] = 0;
    end
    e_rst = '0; e_stole = 0; e_drop = 0;
  endfunction

  function automatic void model_apply(bit on, int note, logic [31:0] freq);
    int match = -1, free = -1, oldest = -1, tgt = -1;
    e_rst = '0; e_stole = 0; e_drop = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_active[i] && m_note[i] == note && match < 0) match = i;
      if (!m_active[i] && free < 0) free = i;
      if (m_active[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    end
    if (on) begin
      if (match >= 0) tgt = match;
      else if (free >= 0) tgt = free;
      else begin
`ifdef VOICE_STEAL_EN
        tgt = oldest;
        e_stole = 1;
`else
        e_drop = 1;
`endif
      end
      if (tgt >= 0) begin
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_active[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_active[tgt] = 1; m_note[tgt] = note; m_freq[tgt] = freq; m_age[tgt] = 0;
        e_rst[tgt] = 1'b1;
      end
    end else if (match >= 0) begin
      m_active[match] = 0;
      m_age[match] = 0;
    end
  endfunction

  function automatic logic [NV-1:0] exp_ce();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_active[i];
    return v;
  endfunction

  function automatic logic [32*NV-1:0] exp_freq();
    logic [32*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[32*i +: 32] = m_freq[i];
    return v;
  endfunction

  // One full request: handshake, wait for commit, compare, then confirm pulses end.
  task automatic send_req(input bit on, input int note, input logic [31:0] freq, input string tag);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s ready_timeout: Req_ready=%b required 1", tag, req_ready);
      return;
    end
    req_valid = 1'b1; req_on = on; req_note = 7'(note); req_freq = freq;
    @(posedge clk); #1;
    req_valid = 1'b0; req_on = 1'($urandom); req_note = 7'($urandom); req_freq = $urandom;
    repeat (NV) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_busy: Req_ready=%b required 0", tag, req_ready);
    end
    @(posedge clk); #1;
    model_apply(on, note, freq);
    $display("txn %s on=%0d note=%0d freq=%h ce=%b rst=%b stole=%b dropped=%b",
             tag, on, note, freq, voice_ce, voice_rst, stole, dropped);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_back: Req_ready=%b required 1", tag, req_ready);
    end
    checks++;
    if (voice_ce !== exp_ce()) begin
      errors++; $display("FAIL %s ce: got %b required %b", tag, voice_ce, exp_ce());
    end
    checks++;
    if (voice_freq !== exp_freq()) begin
      errors++; $display("FAIL %s freq: got %h required %h", tag, voice_freq, exp_freq());
    end
    checks++;
    if (voice_rst !== e_rst) begin
      errors++; $display("FAIL %s voice_rst: got %b required %b", tag, voice_rst, e_rst);
    end
    checks++;
    if (stole !== e_stole || dropped !== e_drop) begin
      errors++;
      $display("FAIL %s stole_dropped: got %b%b required %b%b", tag, stole, dropped, e_stole, e_drop);
    end
    @(posedge clk); #1;
    checks++;
    if (voice_rst !== '0 || stole !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_len: rst=%b stole=%b dropped=%b required all 0", tag, voice_rst, stole, dropped);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (req_ready !== 1'b0 || voice_ce !== '0 || voice_freq !== '0 || voice_rst !== '0 ||
        stole !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: ready=%b ce=%b freq=%h rst=%b required all 0", req_ready, voice_ce, voice_freq, voice_rst);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: Req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_single_note();
    send_req(1, 60, 32'h0000_1000, "single");
    checks++;
    if (voice_ce[0] !== 1'b1 || voice_freq[31:0] !== 32'h0000_1000) begin
      errors++; $display("FAIL single_voice0: ce=%b freq=%h required 1 00001000", voice_ce[0], voice_freq[31:0]);
    end
  endtask

  task automatic test_fill();
    send_req(1, 60, 32'h0000_1000, "fill60");
    send_req(1, 62, 32'h0000_1100, "fill62");
    send_req(1, 64, 32'h0000_1200, "fill64");
    send_req(1, 65, 32'h0000_1300, "fill65");
    checks++;
    if (voice_ce !== 4'b1111) begin
      errors++; $display("FAIL fill_all: ce=%b required 1111", voice_ce);
    end
  endtask

  task automatic test_all_busy();
    send_req(1, 67, 32'h0000_1400, "busy67");
`ifdef VOICE_STEAL_EN
    checks++;
    if (voice_freq[31:0] !== 32'h0000_1400) begin
      errors++; $display("FAIL steal_voice0: freq=%h required 00001400", voice_freq[31:0]);
    end
`else
    checks++;
    if (voice_freq !== {32'h0000_1300, 32'h0000_1200, 32'h0000_1100, 32'h0000_1000}) begin
      errors++; $display("FAIL drop_unchanged: freq=%h", voice_freq);
    end
`endif
  endtask

  task automatic test_retrigger();
    send_req(1, 62, 32'h0000_2000, "retrig62");
    checks++;
    if (voice_freq[63:32] !== 32'h0000_2000 || voice_ce !== 4'b1111) begin
      errors++; $display("FAIL retrig_voice1: freq=%h ce=%b required 00002000 1111", voice_freq[63:32], voice_ce);
    end
  endtask

  task automatic test_note_off();
    send_req(0, 64, 32'hDEAD_BEEF, "off64");
    checks++;
    if (voice_ce[2] !== 1'b0 || voice_freq[95:64] !== 32'h0000_1200) begin
      errors++; $display("FAIL off_voice2: ce=%b freq=%h required 0 00001200", voice_ce[2], voice_freq[95:64]);
    end
    send_req(0, 70, 32'h0, "off70");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      send_req($urandom_range(0, 3) != 0, 60 + $urandom_range(0, 7), $urandom, "rand");
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    req_valid = 1'b1; req_on = 1'b1; req_note = 7'd90; req_freq = 32'h0000_5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || voice_ce !== '0 || voice_freq !== '0 || voice_rst !== '0 ||
        stole !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset: ready=%b ce=%b freq=%h rst=%b required all 0", req_ready, voice_ce, voice_freq, voice_rst);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || voice_ce !== '0) begin
      errors++; $display("FAIL midscan_hold: ready=%b ce=%b required 0 0000", req_ready, voice_ce);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || voice_ce !== '0) begin
      errors++; $display("FAIL midscan_release: ready=%b ce=%b required 1 0000", req_ready, voice_ce);
    end
    send_req(1, 72, 32'h0000_7777, "after_rst");
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_fill();
    test_all_busy();
    test_retrigger();
    test_note_off();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
